lab3_sequencer: RTL and testbench

Self-checking sequencer for the 3-input combinational unit `labThreeCode` (inputs X, Y, Z; output F). On `start` it drives all eight input combinations, waits a programmable settle time per vector, and samples F. Each sample is compared against a truth-table parameter, and the block reports a mismatch count, a per-vector fail bitmap and a pass flag. It sits beside the combinational unit in place of a hand-stepped bench, so the same check also runs on hardware.

---
 rtl/lab3_sequencer_pkg.sv | 11 +
 rtl/lab3_sequencer_settle_timer.sv | 15 +
 rtl/lab3_sequencer.sv | 69 ++++++
 tb/tb_lab3_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lab3_sequencer_pkg.sv
// lab3_sequencer_pkg: FSM state encodings and vector count shared by the sequencer files
package lab3_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
  localparam int NUM_VEC = 8;
  localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);
endpackage

// File: rtl/lab3_sequencer_settle_timer.sv
// lab3_sequencer_settle_timer: 4-bit load/decrement counter (clk, rst, load, load_val in; zero out), stops at 0
module lab3_sequencer_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] cnt;
  assign zero = cnt == 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 4'd1;
endmodule

// File: rtl/lab3_sequencer.sv
// lab3_sequencer: drives X/Y/Z through all 8 vectors on start, samples F after SETTLE_CYCLES, reports busy/done/pass/mismatch_cnt/fail_vec
module lab3_sequencer
  import lab3_sequencer_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       F,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_cnt,
  output logic [7:0] fail_vec
);
  state_t state, next_state;
  logic [2:0] idx;
  logic timer_zero, go, sample, load;
  assign {X, Y, Z} = idx;
  assign busy = state == ST_SETTLE || state == ST_SAMPLE;
  assign pass = done && mismatch_cnt == 4'd0;
  assign go = start && !busy;
  assign sample = state == ST_SAMPLE && !abort;
  assign load = next_state == ST_SETTLE && state != ST_SETTLE;
  lab3_sequencer_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .zero     (timer_zero)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      ST_SETTLE: next_state = abort ? ST_IDLE : timer_zero ? ST_SAMPLE : ST_SETTLE;
      ST_SAMPLE: next_state = abort ? ST_IDLE : idx == LAST_IDX ? ST_DONE : ST_SETTLE;
      default:   next_state = start ? ST_SETTLE : state;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx          <= '0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
      fail_vec     <= '0;
    end else begin
      done <= next_state == ST_DONE;
      if (go) begin
        idx          <= '0;
        mismatch_cnt <= '0;
        fail_vec     <= '0;
      end else if (sample) begin
        if (F != EXPECTED[idx]) begin
          mismatch_cnt  <= mismatch_cnt + 4'd1;
          fail_vec[idx] <= 1'b1;
        end
        if (idx != LAST_IDX) idx <= idx + 3'd1;
      end else if (busy && abort) idx <= '0;
    end
endmodule

// File: tb/tb_lab3_sequencer.sv
// tb_lab3_sequencer: directed bench for lab3_sequencer with a behavioural stand-in for the combinational unit
module tb_lab3_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [2:0] va, vb, vc;
  logic fa, fb, fc;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic [7:0] fv_a, fv_b, fv_c;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  function automatic logic unit_f(input logic [2:0] v);
    return (v[2] & v[1]) | (~v[2] & v[0]);
  endfunction
  assign fa = unit_f(va);
  assign fb = unit_f(vb);
  assign fc = unit_f(vc);
  lab3_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(8'hCA)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .F(fa),
    .X(va[2]), .Y(va[1]), .Z(va[0]), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_cnt(cnt_a), .fail_vec(fv_a));
  lab3_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(8'hEB)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .F(fb),
    .X(vb[2]), .Y(vb[1]), .Z(vb[0]), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_cnt(cnt_b), .fail_vec(fv_b));
  lab3_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(8'hCA)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .F(fc),
    .X(vc[2]), .Y(vc[1]), .Z(vc[0]), .busy(busy_c), .done(done_c), .pass(pass_c),
    .mismatch_cnt(cnt_c), .fail_vec(fv_c));
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_xyz", 8'(va), 8'h00);
    chk("rst_busy", 8'(busy_a), 8'h00);
    chk("rst_done", 8'(done_a), 8'h00);
    chk("rst_pass", 8'(pass_a), 8'h00);
    chk("rst_cnt", 8'(cnt_a), 8'h00);
    chk("rst_fv", fv_a, 8'h00);
    tick(20);
    chk("idle20_busy", 8'(busy_a), 8'h00);
    chk("idle20_done", 8'(done_a), 8'h00);
    chk("idle20_xyz", 8'(va), 8'h00);
    pulse_start;
    chk("run_c0_busy", 8'(busy_a), 8'h01);
    chk("run_c0_xyz", 8'(va), 8'h00);
    tick(5);
    pulse_start;
    chk("busy_start_xyz_a", 8'(va), 8'h02);
    chk("busy_start_xyz_c", 8'(vc), 8'h03);
    tick(9);
    chk("c_done_c15", 8'(done_c), 8'h00);
    tick(1);
    chk("c_done_c16", 8'(done_c), 8'h01);
    chk("c_pass", 8'(pass_c), 8'h01);
    chk("c_cnt", 8'(cnt_c), 8'h00);
    tick(7);
    chk("a_done_c23", 8'(done_a), 8'h00);
    tick(1);
    chk("a_done_c24", 8'(done_a), 8'h01);
    chk("a_pass", 8'(pass_a), 8'h01);
    chk("a_cnt", 8'(cnt_a), 8'h00);
    chk("a_fv", fv_a, 8'h00);
    chk("a_xyz_done", 8'(va), 8'h07);
    chk("a_busy_done", 8'(busy_a), 8'h00);
    chk("b_done", 8'(done_b), 8'h01);
    chk("b_cnt", 8'(cnt_b), 8'h02);
    chk("b_fv", fv_b, 8'h21);
    chk("b_pass", 8'(pass_b), 8'h00);
    pulse_start;
    chk("rerun_b_cnt_clr", 8'(cnt_b), 8'h00);
    chk("rerun_b_fv_clr", fv_b, 8'h00);
    chk("rerun_b_done_clr", 8'(done_b), 8'h00);
    chk("rerun_b_busy", 8'(busy_b), 8'h01);
    tick(24);
    chk("rerun_b_done", 8'(done_b), 8'h01);
    chk("rerun_b_cnt", 8'(cnt_b), 8'h02);
    chk("rerun_b_fv", fv_b, 8'h21);
    pulse_start;
    tick(10);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", 8'(busy_a), 8'h00);
    chk("abort_done", 8'(done_a), 8'h00);
    chk("abort_xyz", 8'(va), 8'h00);
    chk("abort_b_cnt", 8'(cnt_b), 8'h01);
    chk("abort_b_fv", fv_b, 8'h01);
    tick(3);
    chk("abort_idle_stay", 8'(busy_a), 8'h00);
    pulse_start;
    chk("restart_busy", 8'(busy_a), 8'h01);
    tick(24);
    chk("restart_done", 8'(done_a), 8'h01);
    chk("restart_pass", 8'(pass_a), 8'h01);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_in_done", 8'(done_a), 8'h01);
    pulse_start;
    tick(3);
    chk("pre_rst_b_cnt", 8'(cnt_b), 8'h01);
    chk("pre_rst_xyz", 8'(va), 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 8'(busy_a), 8'h00);
    chk("async_rst_xyz", 8'(va), 8'h00);
    chk("async_rst_b_cnt", 8'(cnt_b), 8'h00);
    chk("async_rst_b_fv", fv_b, 8'h00);
    #2 rst = 1'b0;
    tick(1);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 8'(busy_c), 8'h01);
    tick(15);
    chk("post_rst_c_c15", 8'(done_c), 8'h00);
    tick(1);
    chk("post_rst_c_c16", 8'(done_c), 8'h01);
    chk("post_rst_c_pass", 8'(pass_c), 8'h01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
